priority_dec_16: RTL and testbench
==================================

Name: priority_dec_16

Overview:
- Inverse of the 16-bit leading-one priority encoder. Takes a 5-bit leading-one position code (0 = zero value, k = MSB at bit k-1) plus a truncated fraction. Rebuilds the 16-bit linear value.
- Used on the log-domain return path: encoder output, then log-domain arithmetic, then this block back to linear.
- Two-stage registered pipeline with valid/ready handshakes on both sides.

Parameters:
- FRAC_W, 4, width of the fraction field placed directly below the leading one; legal range 1..15.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk edge.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat this cycle.
- in_pos  input  5  leading-one position code; 0..16 legal, 17..31 out of range.
- in_frac  input  FRAC_W  fraction bits, MSB first, below the leading one.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_val  output  16  reconstructed linear value.
- out_err  output  1  beat carried an out-of-range in_pos.

Behaviour:
- Reset: when rst_n = 0 at a rising edge, clear both stage valids. out_valid = 0, out_val = 16'h0000, out_err = 0. In-flight beats are dropped with no output. in_ready = 1 in the cycle after reset.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - in_pos, in_frac and in_valid are held stable while in_valid && !in_ready.
  - Output is held stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers pos, frac, a one-hot of bit pos-1 and a range-error flag.
  - S2 registers out_val and out_err.
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 beat per cycle.
- Advance rules:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 loads when S1 is empty or S1 moves into S2.
  - in_ready = !s1_valid || s2_can_load. This is combinational from out_ready; there is no other combinational in-to-out path.
  - No bubbles under continuous valid and ready. No beat is lost or duplicated under any stall pattern.
- Decode rules, with p = in_pos:
  - p = 0: out_val = 0. in_frac is ignored.
  - 1 ≤ p ≤ 16: out_val bit p-1 = 1.
  - Fraction bits fill positions p-2 downward, MSB first. Bits that would fall below bit 0 are truncated, with no rounding.
  - If p-1 > FRAC_W, the bits below the fraction are 0.
  - p ≥ 17: out_val = 16'hFFFF (saturate) and out_err = 1. Otherwise out_err = 0.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both honoured.
  - Reset overrides everything.

Optional Feature:
- Macro: PRIORITY_DEC_THERMO_EN.
- Defined:
  - Adds output port out_mask (16 bits), registered in S2 and aligned with out_val.
  - out_mask has bits p-1..0 set: p = 0 gives 16'h0000, p = 16 gives 16'hFFFF, p ≥ 17 gives 16'hFFFF.
  - out_mask resets to 16'h0000.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then pos = 5, frac = 4'b1010, out_ready = 1 held -> out_valid rises 2 cycles after the transfer; out_val = 16'h001A, out_err = 0.
- Back-to-back beats pos = 16/frac = 4'hF, pos = 3/frac = 4'b1011, pos = 0/frac = 4'hF, out_ready = 1 -> outputs 16'hF800, 16'h0006, 16'h0000 on consecutive cycles, no bubbles.
- pos = 20, frac = 0 -> out_val = 16'hFFFF, out_err = 1. Next beat pos = 1 -> out_val = 16'h0001, out_err = 0.
- Stall: out_ready = 0 for 5 cycles while 4 beats are offered -> at most 2 accepted, in_ready = 0 once both stages are full, out_val held stable. Release out_ready -> all accepted beats emerge in order, none lost or duplicated.
- Reset asserted with both stages full -> next cycle out_valid = 0, out_val = 0, in_ready = 1; no stale beat emerges.
- With PRIORITY_DEC_THERMO_EN: pos = 5 -> out_mask = 16'h001F; pos = 0 -> 16'h0000; pos = 17 -> 16'hFFFF.

Source files
------------

// File: rtl/priority_dec_16_if.sv
// Handshake bundle for priority_dec_16: input beat (pos/frac) and reconstructed output beat.
// out_mask exists only when PRIORITY_DEC_THERMO_EN is defined.
interface priority_dec_16_if #(
   parameter int FRAC_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_pos;
   logic [FRAC_W-1:0] in_frac;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_val;
   logic              out_err;
`ifdef PRIORITY_DEC_THERMO_EN
   logic [15:0]       out_mask;
`endif

   // master drives the input beat and consumes the output beat
   modport master (
      output in_valid, in_pos, in_frac, out_ready,
      input  in_ready, out_valid, out_val, out_err
`ifdef PRIORITY_DEC_THERMO_EN
      , input out_mask
`endif
   );

   modport slave (
      input  in_valid, in_pos, in_frac, out_ready,
      output in_ready, out_valid, out_val, out_err
`ifdef PRIORITY_DEC_THERMO_EN
      , output out_mask
`endif
   );
endinterface

// File: rtl/priority_dec_16.sv
// Leading-one position code + fraction back to a 16-bit linear value, 2-stage valid/ready pipeline.
// Optional thermometer mask output enabled by PRIORITY_DEC_THERMO_EN.
module priority_dec_16 #(
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   priority_dec_16_if.slave  bus
);
   logic              s1_valid_reg;
   logic [4:0]        s1_pos_reg;
   logic [FRAC_W-1:0] s1_frac_reg;
   logic [15:0]       s1_onehot_reg;
   logic              s1_err_reg;

   logic              s2_valid_reg;
   logic [15:0]       s2_val_reg;
   logic              s2_err_reg;

   logic [15:0]       onehot_next;
   logic [15:0]       frac_bits;
   logic [15:0]       val_next;
   logic              err_next;
   logic              s2_load;
   logic              s1_load;

   assign s2_load      = !s2_valid_reg || bus.out_ready;
   assign s1_load      = !s1_valid_reg || s2_load;
   assign bus.in_ready = s1_load;
   assign err_next     = (bus.in_pos > 5'd16);

   // Output bit gi takes fraction bit j when gi = pos-2-(FRAC_W-1-j); bits below 0 simply never match.
   for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      logic frac_hit;
      assign onehot_next[gi] = (bus.in_pos == 5'(gi + 1));
      always_comb begin
         frac_hit = 1'b0;
         for (int j = 0; j < FRAC_W; j++) begin
            if (int'(s1_pos_reg) == gi + 1 + FRAC_W - j)
               frac_hit = s1_frac_reg[j];
         end
      end
      assign frac_bits[gi] = frac_hit;
   end

   assign val_next = s1_err_reg ? 16'hFFFF : (s1_onehot_reg | frac_bits);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_pos_reg    <= 5'd0;
         s1_frac_reg   <= '0;
         s1_onehot_reg <= 16'h0000;
         s1_err_reg    <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            s1_pos_reg    <= bus.in_pos;
            s1_frac_reg   <= bus.in_frac;
            s1_onehot_reg <= onehot_next;
            s1_err_reg    <= err_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_val_reg   <= 16'h0000;
         s2_err_reg   <= 1'b0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_val_reg <= val_next;
            s2_err_reg <= s1_err_reg;
         end
      end
   end

   assign bus.out_valid = s2_valid_reg;
   assign bus.out_val   = s2_val_reg;
   assign bus.out_err   = s2_err_reg;

`ifdef PRIORITY_DEC_THERMO_EN
   logic [15:0] s2_mask_reg;
   logic [15:0] mask_next;

   // One-hot at bit p-1 smeared downward gives bits p-1..0.
   always_comb begin
      mask_next = 16'h0000;
      if (s1_err_reg)
         mask_next = 16'hFFFF;
      else if (s1_onehot_reg != 16'h0000)
         mask_next = s1_onehot_reg | (s1_onehot_reg - 16'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         s2_mask_reg <= 16'h0000;
      else if (s2_load && s1_valid_reg)
         s2_mask_reg <= mask_next;
   end

   assign bus.out_mask = s2_mask_reg;
`endif
endmodule

// File: tb/tb_priority_dec_16.sv
// Randomized + directed bench for priority_dec_16 with an arithmetic reference model and scoreboard.
// Define PRIORITY_DEC_THERMO_EN to also check out_mask.
module tb_priority_dec_16;
   localparam int FW = 4;

   typedef struct {
      logic [15:0] val;
      logic        err;
      logic [15:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic held_valid = 1'b0;
   logic [15:0] held_val;
   logic held_err;
   logic acc;

   always #5 clk = ~clk;

   priority_dec_16_if #(.FRAC_W(FW)) bus ();
   priority_dec_16 #(.FRAC_W(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Value is (1.frac) * 2^(pos-1), truncated to an integer.
   function automatic exp_t model(input int p, input int f);
      exp_t e;
      longint m;
      e.err = (p >= 17);
      if (p == 0) begin
         e.val = 16'h0000; e.mask = 16'h0000;
      end else if (p >= 17) begin
         e.val = 16'hFFFF; e.mask = 16'hFFFF;
      end else begin
         m = ((longint'(1) << FW) + longint'(f)) << (p - 1);
         e.val = 16'(m >> FW);
         e.mask = 16'((longint'(1) << p) - 1);
      end
      return e;
   endfunction

   task automatic step(input logic iv, input int p, input int f, input logic ordy, output logic accepted);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_pos    = 5'(p);
      bus.in_frac   = FW'(f);
      bus.out_ready = ordy;
      #1;
      if (held_valid) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_val", 32'(bus.out_val), 32'(held_val));
         check("hold_err", 32'(bus.out_err), 32'(held_err));
         held_valid = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_val", 32'(bus.out_val), 32'(e.val));
            check("out_err", 32'(bus.out_err), 32'(e.err));
`ifdef PRIORITY_DEC_THERMO_EN
            check("out_mask", 32'(bus.out_mask), 32'(e.mask));
`endif
            $display("beat val=%h err=%0d", bus.out_val, bus.out_err);
         end
      end else if (bus.out_valid) begin
         held_valid = 1'b1;
         held_val   = bus.out_val;
         held_err   = bus.out_err;
      end
      accepted = iv && bus.in_ready;
      if (accepted) exp_q.push_back(model(p, f));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      held_valid = 1'b0;
   endtask

   task automatic drain();
      logic a;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++)
         step(1'b0, 0, 0, 1'b1, a);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(bus.out_valid), 32'd0);
   endtask

   int sp [4];
   int sf [4];
   int idx;

   initial begin
      bus.in_valid = 1'b0; bus.in_pos = 5'd0; bus.in_frac = '0; bus.out_ready = 1'b0;
      do_reset();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_val", 32'(bus.out_val), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single beat: latency 2
      step(1'b1, 5, 4'b1010, 1'b1, acc);
      check("lat_accept", 32'(acc), 32'd1);
      check("lat_cycle1", 32'(bus.out_valid), 32'd0);
      step(1'b0, 0, 0, 1'b1, acc);
      check("lat_cycle2", 32'(bus.out_valid), 32'd1);
      check("lat_val", 32'(bus.out_val), 32'h001A);
      drain();

      // Back-to-back, no bubbles
      step(1'b1, 16, 4'hF, 1'b1, acc);
      step(1'b1, 3, 4'b1011, 1'b1, acc);
      check("b2b_v1", 32'(bus.out_valid), 32'd1);
      check("b2b_val1", 32'(bus.out_val), 32'hF800);
      step(1'b1, 0, 4'hF, 1'b1, acc);
      check("b2b_v2", 32'(bus.out_valid), 32'd1);
      step(1'b0, 0, 0, 1'b1, acc);
      check("b2b_v3", 32'(bus.out_valid), 32'd1);
      step(1'b0, 0, 0, 1'b1, acc);
      check("b2b_v4", 32'(bus.out_valid), 32'd0);
      drain();

      // Out-of-range then pos=1
      step(1'b1, 20, 0, 1'b1, acc);
      step(1'b1, 1, 0, 1'b1, acc);
      check("sat_val", 32'(bus.out_val), 32'hFFFF);
      check("sat_err", 32'(bus.out_err), 32'd1);
      drain();

      // Stall: 5 cycles out_ready=0, 4 beats offered
      sp = '{7, 12, 2, 17}; sf = '{3, 9, 15, 0};
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         step(1'b1, sp[idx], sf[idx], 1'b0, acc);
         if (acc) idx++;
      end
      check("stall_accepted", 32'(idx), 32'd2);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      for (int c = 0; c < 20 && idx < 4; c++) begin
         step(1'b1, sp[idx], sf[idx], 1'b1, acc);
         if (acc) idx++;
      end
      check("stall_all_sent", 32'(idx), 32'd4);
      drain();

      // Reset with both stages full
      step(1'b1, 9, 5, 1'b0, acc);
      step(1'b1, 10, 6, 1'b0, acc);
      step(1'b0, 0, 0, 1'b0, acc);
      check("full_valid", 32'(bus.out_valid), 32'd1);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      do_reset();
      check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst2_out_val", 32'(bus.out_val), 32'd0);
      check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 0, 0, 1'b1, acc);
         check("rst2_no_stale", 32'(bus.out_valid), 32'd0);
      end

`ifdef PRIORITY_DEC_THERMO_EN
      step(1'b1, 5, 0, 1'b1, acc);
      step(1'b1, 0, 0, 1'b1, acc);
      check("mask_p5", 32'(bus.out_mask), 32'h001F);
      step(1'b1, 17, 0, 1'b1, acc);
      check("mask_p0", 32'(bus.out_mask), 32'h0000);
      step(1'b0, 0, 0, 1'b1, acc);
      check("mask_p17", 32'(bus.out_mask), 32'hFFFF);
      drain();
`endif

      // Random traffic with random stalls; held beats kept stable until accepted
      begin
         logic pend = 1'b0;
         logic iv = 1'b0;
         int   p = 0, f = 0;
         for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
               iv = ($urandom_range(0, 9) < 7);
               p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
               f  = int'($urandom_range(0, (1 << FW) - 1));
            end
            step(iv, p, f, ($urandom_range(0, 9) < 6), acc);
            pend = iv && !acc;
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
